// File: rtl/sdram_access_scheduler.sv
// Access scheduler between two user request ports and the SDRAM command engine.
// Round-robin user arbitration, timer-driven auto-refresh with priority, one operation in flight.
module sdram_access_scheduler #(
    parameter int clock_frequency     = 100_000_000,
    parameter int refresh_interval_ns = 7_812,
    parameter int max_postponed       = 8,
    parameter int addr_width          = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  initiated,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [addr_width-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [addr_width-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_type,
    output logic [addr_width-1:0] cmd_addr,
    output logic                  cmd_source,
    input  logic                  cmd_ready,
    input  logic                  cmd_done,
    output logic [3:0]            refresh_pending,
    output logic                  refresh_overdue
);

    localparam int NS_PER_CLK     = 1_000_000_000 / clock_frequency;
    localparam int REFRESH_CYCLES = refresh_interval_ns / NS_PER_CLK;
    localparam int TIMER_W        = $clog2(REFRESH_CYCLES);

    localparam logic [1:0] CMD_READ    = 2'b00;
    localparam logic [1:0] CMD_REFRESH = 2'b10;
    localparam logic [3:0] PEND_MAX    = 4'(max_postponed);
    localparam logic [3:0] PEND_SAT    = 4'(max_postponed - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            type_q, type_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  src_q, src_d;
    logic                  last_q, last_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [3:0]            pend_q, pend_d;
    logic                  ovd_q, ovd_d;

    logic tick;
    logic refresh_due;
    logic refresh_hs;
    logic grant1;

    assign tick        = initiated && (timer_q == TIMER_LAST);
    // A tick in the IDLE cycle itself already outranks user traffic.
    assign refresh_due = (pend_q != 4'd0) || tick;
    assign refresh_hs  = (state_q == S_ISSUE) && cmd_ready && (type_q == CMD_REFRESH);

    always_comb begin
        timer_d = timer_q;
        pend_d  = pend_q;
        ovd_d   = ovd_q;
        if (!initiated) begin
            timer_d = '0;
            pend_d  = 4'd0;
        end else begin
            timer_d = tick ? '0 : timer_q + 1'b1;
            if (tick && !refresh_hs) begin
                if (pend_q >= PEND_SAT) begin
                    pend_d = PEND_MAX;
                    ovd_d  = 1'b1;
                end else begin
                    pend_d = pend_q + 4'd1;
                end
            end else if (refresh_hs && !tick && (pend_q != 4'd0)) begin
                pend_d = pend_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        src_d      = src_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant1     = req1_valid && (!req0_valid || !last_q);
        case (state_q)
            S_IDLE: begin
                if (initiated && !reset) begin
                    if (refresh_due) begin
                        type_d  = CMD_REFRESH;
                        addr_d  = '0;
                        src_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else if (grant1) begin
                        req1_ready = 1'b1;
                        type_d     = {1'b0, req1_write};
                        addr_d     = req1_addr;
                        src_d      = 1'b1;
                        last_d     = 1'b1;
                        state_d    = S_ISSUE;
                    end else if (req0_valid) begin
                        req0_ready = 1'b1;
                        type_d     = {1'b0, req0_write};
                        addr_d     = req0_addr;
                        src_d      = 1'b0;
                        last_d     = 1'b0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (cmd_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            type_q  <= CMD_READ;
            addr_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            timer_q <= '0;
            pend_q  <= 4'd0;
            ovd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovd_q   <= ovd_d;
        end
    end

    assign cmd_valid       = (state_q == S_ISSUE);
    assign cmd_type        = type_q;
    assign cmd_addr        = addr_q;
    assign cmd_source      = src_q;
    assign refresh_pending = pend_q;
    assign refresh_overdue = ovd_q;

endmodule
